shell_ctrl: RTL and testbench

- Consumes the tank's outputs: position plus the sin/cos pair that the tank's angle LUT produces. Also consumes the shared 32-bit keyboard keycode word.
- Spawns and advances up to NUM_SHELLS projectiles, one update per frame_clk.
- Shells bounce off the screen edges and expire on lifetime or bounce count.
- Drives the shell positions and active flags to the color mapper and collision logic.

---
 rtl/tank_pkg.sv | 41 ++++
 rtl/shell_slot.sv | 99 +++++++++
 rtl/shell_ctrl.sv | 101 ++++++++++
 tb/tb_shell_ctrl.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tank_pkg.sv
// Shared tank-game constants, shell record and sign-magnitude velocity scaling.
// Pure definitions: no latency, no flow control.
// Backpressure: none.
package tank_pkg;

  localparam logic [9:0] X_MIN = 10'd0;
  localparam logic [9:0] X_MAX = 10'd639;
  localparam logic [9:0] Y_MIN = 10'd0;
  localparam logic [9:0] Y_MAX = 10'd479;

  localparam logic [7:0] KEY_FIRE  = 8'h2C;
  localparam logic [7:0] KEY_RIGHT = 8'h4F;
  localparam logic [7:0] KEY_LEFT  = 8'h50;
  localparam logic [7:0] KEY_DOWN  = 8'h51;
  localparam logic [7:0] KEY_UP    = 8'h52;

  typedef enum logic {
    SLOT_IDLE = 1'b0,
    SLOT_FLY  = 1'b1
  } slot_state_t;

  typedef struct packed {
    logic        [9:0] x;
    logic        [9:0] y;
    logic signed [9:0] vx;
    logic signed [9:0] vy;
    logic        [9:0] life;
    logic        [2:0] bounces;
    logic              active;
  } shell_t;

  // Q0.7 magnitude times speed, truncated toward zero, negated when bit7 is set.
  function automatic logic signed [9:0] sm_scale(input logic [7:0] sm8, input logic [6:0] speed);
    logic [13:0] prod;
    logic [9:0]  mag;
    prod = {7'd0, sm8[6:0]} * {7'd0, speed};
    mag  = {3'b000, prod[13:7]};
    return sm8[7] ? $signed(-mag) : $signed(mag);
  endfunction

endpackage

// File: rtl/shell_slot.sv
// One shell slot: IDLE/FLY FSM, edge bounce and lifetime (SHELL_KILL_EN adds a kill input).
// Latency: load visible one frame later, first move the frame after that.
// Backpressure: none; load_vld is only honoured in IDLE.
module shell_slot
  import tank_pkg::*;
#(
  parameter logic [9:0] LIFETIME   = 10'd300,
  parameter logic [2:0] MAX_BOUNCE = 3'd3,
  parameter logic [9:0] SHELL_R    = 10'd2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_vld,
  input  logic [9:0]        load_x,
  input  logic [9:0]        load_y,
  input  logic signed [9:0] load_vx,
  input  logic signed [9:0] load_vy,
`ifdef SHELL_KILL_EN
  input  logic              kill,
`endif
  output logic [9:0]        slot_x,
  output logic [9:0]        slot_y,
  output logic              slot_active
);

  localparam logic signed [10:0] R_S    = $signed({1'b0, SHELL_R});
  localparam logic signed [10:0] XMAX_S = $signed({1'b0, X_MAX});
  localparam logic signed [10:0] XMIN_S = $signed({1'b0, X_MIN});
  localparam logic signed [10:0] YMAX_S = $signed({1'b0, Y_MAX});
  localparam logic signed [10:0] YMIN_S = $signed({1'b0, Y_MIN});

  slot_state_t state_q, state_d;
  shell_t      shell_q, shell_d;
  logic signed [10:0] nx, ny;
  logic        hit_x, hit_y;
  logic        kill_i;

`ifdef SHELL_KILL_EN
  assign kill_i = kill;
`else
  assign kill_i = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    shell_d = shell_q;
    nx      = $signed({1'b0, shell_q.x}) + $signed({shell_q.vx[9], shell_q.vx});
    ny      = $signed({1'b0, shell_q.y}) + $signed({shell_q.vy[9], shell_q.vy});
    hit_x   = (nx + R_S >= XMAX_S) || (nx - R_S <= XMIN_S);
    hit_y   = (ny + R_S >= YMAX_S) || (ny - R_S <= YMIN_S);
    unique case (state_q)
      SLOT_IDLE: begin
        if (load_vld) begin
          state_d         = SLOT_FLY;
          shell_d.x       = load_x;
          shell_d.y       = load_y;
          shell_d.vx      = load_vx;
          shell_d.vy      = load_vy;
          shell_d.life    = LIFETIME;
          shell_d.bounces = 3'd0;
        end
      end
      SLOT_FLY: begin
        if (kill_i) begin
          state_d = SLOT_IDLE;
        end else begin
          // A bounced axis keeps its position and reverses; the other axis still moves.
          if (hit_x) shell_d.vx = -shell_q.vx;
          else       shell_d.x  = nx[9:0];
          if (hit_y) shell_d.vy = -shell_q.vy;
          else       shell_d.y  = ny[9:0];
          shell_d.life = shell_q.life - 10'd1;
          if (hit_x || hit_y) begin
            if (shell_q.bounces == MAX_BOUNCE) state_d = SLOT_IDLE;
            else shell_d.bounces = shell_q.bounces + 3'd1;
          end
          if (shell_q.life == 10'd1) state_d = SLOT_IDLE;
        end
      end
      default: state_d = SLOT_IDLE;
    endcase
    shell_d.active = (state_d == SLOT_FLY);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SLOT_IDLE;
      shell_q <= '0;
    end else begin
      state_q <= state_d;
      shell_q <= shell_d;
    end
  end

  assign slot_x      = shell_q.x;
  assign slot_y      = shell_q.y;
  assign slot_active = shell_q.active;

endmodule

// File: rtl/shell_ctrl.sv
// Shell manager: fire edge-detect, cooldown, lowest-free-slot allocator, NUM_SHELLS slots (SHELL_KILL_EN adds ShellKill).
// Latency: accepted fire shows the shell at the tank one frame later; all outputs registered.
// Backpressure: a fire with no free slot or a running cooldown is dropped.
module shell_ctrl
  import tank_pkg::*;
#(
  parameter int         NUM_SHELLS = 4,
  parameter logic [6:0] SPEED      = 7'd6,
  parameter logic [9:0] LIFETIME   = 10'd300,
  parameter logic [2:0] MAX_BOUNCE = 3'd3,
  parameter logic [5:0] COOLDOWN   = 6'd15,
  parameter logic [7:0] FIRE_KEY   = KEY_FIRE,
  parameter logic [9:0] SHELL_R    = 10'd2
) (
  input  logic                    frame_clk,
  input  logic                    Reset,
  input  logic [9:0]              TankX,
  input  logic [9:0]              TankY,
  input  logic [7:0]              sin,
  input  logic [7:0]              cos,
  input  logic [31:0]             keycode,
`ifdef SHELL_KILL_EN
  input  logic [NUM_SHELLS-1:0]   ShellKill,
`endif
  output logic [10*NUM_SHELLS-1:0] ShellX,
  output logic [10*NUM_SHELLS-1:0] ShellY,
  output logic [NUM_SHELLS-1:0]   ShellActive,
  output logic [9:0]              ShellS
);

  logic [5:0]            cooldown_q, cooldown_d;
  logic                  fire_prev_q, fire_prev_d;
  logic                  key_now, fire_req, free_found, accept;
  logic [NUM_SHELLS-1:0] alloc, load_vld;
  logic signed [9:0]     spawn_vx, spawn_vy;

  always_comb begin
    key_now = 1'b0;
    for (int b = 0; b < 4; b++) begin
      if (keycode[8*b +: 8] == FIRE_KEY) key_now = 1'b1;
    end
    fire_req    = key_now & ~fire_prev_q;
    fire_prev_d = key_now;

    // Registered active flags are the start-of-frame view, so a slot expiring
    // on this edge is not reusable until the next one.
    free_found = 1'b0;
    alloc      = '0;
    for (int i = 0; i < NUM_SHELLS; i++) begin
      if (!ShellActive[i] && !free_found) begin
        free_found = 1'b1;
        alloc[i]   = 1'b1;
      end
    end
    accept   = fire_req && (cooldown_q == 6'd0) && free_found;
    load_vld = accept ? alloc : '0;

    if (accept)                  cooldown_d = COOLDOWN;
    else if (cooldown_q != 6'd0) cooldown_d = cooldown_q - 6'd1;
    else                         cooldown_d = cooldown_q;

    // Screen Y grows downward, so a positive sine means negative vy.
    spawn_vx = sm_scale(cos, SPEED);
    spawn_vy = sm_scale({~sin[7], sin[6:0]}, SPEED);
  end

  always_ff @(posedge frame_clk or negedge Reset) begin
    if (!Reset) begin
      cooldown_q  <= 6'd0;
      fire_prev_q <= 1'b0;
    end else begin
      cooldown_q  <= cooldown_d;
      fire_prev_q <= fire_prev_d;
    end
  end

  for (genvar g = 0; g < NUM_SHELLS; g++) begin : g_slot
    shell_slot #(
      .LIFETIME   (LIFETIME),
      .MAX_BOUNCE (MAX_BOUNCE),
      .SHELL_R    (SHELL_R)
    ) u_slot (
      .clk         (frame_clk),
      .rst_n       (Reset),
      .load_vld    (load_vld[g]),
      .load_x      (TankX),
      .load_y      (TankY),
      .load_vx     (spawn_vx),
      .load_vy     (spawn_vy),
`ifdef SHELL_KILL_EN
      .kill        (ShellKill[g]),
`endif
      .slot_x      (ShellX[10*g +: 10]),
      .slot_y      (ShellY[10*g +: 10]),
      .slot_active (ShellActive[g])
    );
  end

  assign ShellS = SHELL_R;

endmodule

// File: tb/tb_shell_ctrl.sv
// Scoreboard bench for shell_ctrl: three instances (default, long-life for bouncing, LIFETIME=3).
// SHELL_KILL_EN builds additionally exercise ShellKill.
module tb_shell_ctrl;
  localparam int N = 4;
  localparam int K_MASK = 0, K_X = 1, K_Y = 2, K_CD = 3;
  localparam logic [7:0] FIRE = 8'h2C;

  typedef struct {
    int    frame;
    int    inst;
    int    kind;
    int    slot;
    int    val;
    string name;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;
  int frame  = 0;

  logic          frame_clk = 1'b0;
  logic          Reset = 1'b1;
  logic [9:0]    TankX = 10'd300, TankY = 10'd250;
  logic [7:0]    sin_v = 8'h00, cos_v = 8'h7F;
  logic [31:0]   keycode = 32'd0;
  logic [10*N-1:0] d_x, d_y, b_x, b_y, l_x, l_y;
  logic [N-1:0]  d_act, b_act, l_act;
  logic [9:0]    d_s, b_s, l_s;
`ifdef SHELL_KILL_EN
  logic [N-1:0]  kill_v = '0;
  logic [N-1:0]  no_kill = '0;
`endif

  // Heading table: sin, cos, expected per-frame dx, dy.
  logic [7:0] h_sin [6] = '{8'h00, 8'h7F, 8'h00, 8'hFF, 8'h40, 8'h95};
  logic [7:0] h_cos [6] = '{8'h7F, 8'h00, 8'hFF, 8'h00, 8'h40, 8'h16};
  int         h_dx  [6] = '{5, 0, -5, 0, 3, 1};
  int         h_dy  [6] = '{0, -5, 0, 5, -3, 0};

  shell_ctrl u_dut (
    .frame_clk(frame_clk), .Reset(Reset), .TankX(TankX), .TankY(TankY),
    .sin(sin_v), .cos(cos_v), .keycode(keycode),
`ifdef SHELL_KILL_EN
    .ShellKill(kill_v),
`endif
    .ShellX(d_x), .ShellY(d_y), .ShellActive(d_act), .ShellS(d_s));

  shell_ctrl #(.LIFETIME(10'd1000)) u_bnc (
    .frame_clk(frame_clk), .Reset(Reset), .TankX(TankX), .TankY(TankY),
    .sin(sin_v), .cos(cos_v), .keycode(keycode),
`ifdef SHELL_KILL_EN
    .ShellKill(no_kill),
`endif
    .ShellX(b_x), .ShellY(b_y), .ShellActive(b_act), .ShellS(b_s));

  shell_ctrl #(.LIFETIME(10'd3)) u_life (
    .frame_clk(frame_clk), .Reset(Reset), .TankX(TankX), .TankY(TankY),
    .sin(sin_v), .cos(cos_v), .keycode(keycode),
`ifdef SHELL_KILL_EN
    .ShellKill(no_kill),
`endif
    .ShellX(l_x), .ShellY(l_y), .ShellActive(l_act), .ShellS(l_s));

  always #5 frame_clk = ~frame_clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] observe(input int inst, input int kind, input int slot);
    logic [10*N-1:0] xs, ys;
    logic [N-1:0]    act;
    xs  = (inst == 0) ? d_x : (inst == 1) ? b_x : l_x;
    ys  = (inst == 0) ? d_y : (inst == 1) ? b_y : l_y;
    act = (inst == 0) ? d_act : (inst == 1) ? b_act : l_act;
    case (kind)
      K_MASK:  return {28'd0, act};
      K_X:     return {22'd0, xs[10*slot +: 10]};
      K_Y:     return {22'd0, ys[10*slot +: 10]};
      default: return {26'd0, u_dut.cooldown_q};
    endcase
  endfunction

  task automatic expect_at(input int f, input int inst, input int kind, input int slot,
                           input int val, input string name);
    exp_t e;
    e.frame = f; e.inst = inst; e.kind = kind; e.slot = slot; e.val = val; e.name = name;
    sb.push_back(e);
  endtask

  task automatic tick();
    @(posedge frame_clk);
    #1;
    frame++;
  endtask

  task automatic do_reset();
    Reset = 1'b0;
    keycode = 32'd0;
    TankX = 10'd300; TankY = 10'd250; sin_v = 8'h00; cos_v = 8'h7F;
`ifdef SHELL_KILL_EN
    kill_v = '0;
`endif
    sb.delete();
    tick(); tick();
    Reset = 1'b1;
    frame = 0;
  endtask

  task automatic test_reset();
    #2 Reset = 1'b0;
    #1;
    checks++; if (d_act !== 4'b0000) begin errors++; $display("FAIL reset_active: got %b, expected 0000", d_act); end
    checks++; if (d_x !== '0) begin errors++; $display("FAIL reset_x: got %h, expected 0", d_x); end
    checks++; if (d_y !== '0) begin errors++; $display("FAIL reset_y: got %h, expected 0", d_y); end
    checks++; if (b_act !== 4'b0000 || l_act !== 4'b0000) begin errors++; $display("FAIL reset_active_other: got %b/%b, expected 0000", b_act, l_act); end
    checks++; if (u_dut.cooldown_q !== 6'd0) begin errors++; $display("FAIL reset_cooldown: got %0d, expected 0", u_dut.cooldown_q); end
    checks++; if (d_s !== 10'd2) begin errors++; $display("FAIL shell_s: got %0d, expected 2", d_s); end
  endtask

  task automatic test_fire_held();
    exp_t e; logic [31:0] got;
    do_reset();
    expect_at(1, 0, K_MASK, 0, 1, "held_first_mask");
    expect_at(1, 0, K_X, 0, 300, "held_spawn_x");
    expect_at(1, 0, K_Y, 0, 250, "held_spawn_y");
    expect_at(2, 0, K_X, 0, 305, "held_move1_x");
    expect_at(3, 0, K_X, 0, 310, "held_move2_x");
    expect_at(3, 0, K_Y, 0, 250, "held_vy_zero");
    expect_at(10, 0, K_MASK, 0, 1, "held_one_shell");
    for (int f = 1; f <= 10; f++) begin
      keycode = {8'h00, 8'h50, FIRE, 8'h00};
      tick();
      while (sb.size() > 0 && sb[0].frame == frame) begin
        e = sb.pop_front(); got = observe(e.inst, e.kind, e.slot); checks++;
        if (got !== e.val) begin errors++; $display("FAIL %s frame %0d: got %0d, expected %0d", e.name, frame, got, e.val); end
      end
    end
  endtask

  task automatic test_heading();
    exp_t e; logic [31:0] got;
    for (int h = 0; h < 6; h++) begin
      do_reset();
      sin_v = h_sin[h]; cos_v = h_cos[h];
      expect_at(1, 0, K_X, 0, 300, $sformatf("heading%0d_x0", h));
      expect_at(1, 0, K_Y, 0, 250, $sformatf("heading%0d_y0", h));
      expect_at(2, 0, K_X, 0, 300 + h_dx[h], $sformatf("heading%0d_x1", h));
      expect_at(2, 0, K_Y, 0, 250 + h_dy[h], $sformatf("heading%0d_y1", h));
      expect_at(3, 0, K_X, 0, 300 + 2*h_dx[h], $sformatf("heading%0d_x2", h));
      expect_at(3, 0, K_Y, 0, 250 + 2*h_dy[h], $sformatf("heading%0d_y2", h));
      for (int f = 1; f <= 3; f++) begin
        keycode = (f == 1) ? (32'(FIRE) << (8*(h % 4))) : 32'd0;
        tick();
        while (sb.size() > 0 && sb[0].frame == frame) begin
          e = sb.pop_front(); got = observe(e.inst, e.kind, e.slot); checks++;
          if (got !== e.val) begin errors++; $display("FAIL %s frame %0d: got %0d, expected %0d", e.name, frame, got, e.val); end
        end
      end
    end
  endtask

  task automatic test_alloc_full();
    exp_t e; logic [31:0] got;
    do_reset();
    expect_at(1, 0, K_MASK, 0, 4'b0001, "alloc_slot0");
    expect_at(17, 0, K_MASK, 0, 4'b0011, "alloc_slot1");
    expect_at(33, 0, K_MASK, 0, 4'b0111, "alloc_slot2");
    expect_at(49, 0, K_MASK, 0, 4'b1111, "alloc_slot3");
    expect_at(49, 0, K_CD, 0, 15, "alloc_cd_loaded");
    expect_at(64, 0, K_CD, 0, 0, "alloc_cd_expired");
    expect_at(65, 0, K_MASK, 0, 4'b1111, "alloc_fifth_dropped");
    expect_at(65, 0, K_CD, 0, 0, "alloc_cd_not_loaded");
    expect_at(66, 0, K_CD, 0, 0, "alloc_cd_still_zero");
    for (int f = 1; f <= 66; f++) begin
      keycode = (f % 16 == 1) ? {24'd0, FIRE} : 32'd0;
      tick();
      while (sb.size() > 0 && sb[0].frame == frame) begin
        e = sb.pop_front(); got = observe(e.inst, e.kind, e.slot); checks++;
        if (got !== e.val) begin errors++; $display("FAIL %s frame %0d: got %0d, expected %0d", e.name, frame, got, e.val); end
      end
    end
  endtask

  task automatic test_cooldown();
    exp_t e; logic [31:0] got;
    do_reset();
    expect_at(1, 0, K_MASK, 0, 4'b0001, "cd_first_accept");
    expect_at(1, 0, K_CD, 0, 15, "cd_loaded");
    expect_at(6, 0, K_MASK, 0, 4'b0001, "cd_second_ignored");
    expect_at(6, 0, K_CD, 0, 10, "cd_counting");
    expect_at(16, 0, K_CD, 0, 0, "cd_reached_zero");
    // First edge that samples cooldown==0 after the initial accept.
    expect_at(17, 0, K_MASK, 0, 4'b0011, "cd_third_accept");
    expect_at(17, 0, K_CD, 0, 15, "cd_reloaded");
    for (int f = 1; f <= 17; f++) begin
      keycode = (f == 1 || f == 6 || f == 17) ? {FIRE, 24'd0} : 32'd0;
      tick();
      while (sb.size() > 0 && sb[0].frame == frame) begin
        e = sb.pop_front(); got = observe(e.inst, e.kind, e.slot); checks++;
        if (got !== e.val) begin errors++; $display("FAIL %s frame %0d: got %0d, expected %0d", e.name, frame, got, e.val); end
      end
    end
  endtask

  task automatic test_bounce();
    exp_t e; logic [31:0] got;
    do_reset();
    TankX = 10'd630;
    expect_at(1, 1, K_X, 0, 630, "bnc_spawn");
    expect_at(2, 1, K_X, 0, 635, "bnc_last_move");
    expect_at(3, 1, K_X, 0, 635, "bnc_right_hold");
    expect_at(3, 1, K_MASK, 0, 1, "bnc_alive_after1");
    expect_at(4, 1, K_X, 0, 630, "bnc_reversed");
    expect_at(129, 1, K_X, 0, 5, "bnc_near_left");
    expect_at(130, 1, K_X, 0, 5, "bnc_left_hold");
    expect_at(131, 1, K_X, 0, 10, "bnc_left_reversed");
    expect_at(256, 1, K_X, 0, 635, "bnc_near_right2");
    expect_at(257, 1, K_X, 0, 635, "bnc_right_hold2");
    expect_at(258, 1, K_X, 0, 630, "bnc_reversed3");
    expect_at(383, 1, K_X, 0, 5, "bnc_before_4th");
    expect_at(383, 1, K_MASK, 0, 1, "bnc_alive_before_4th");
    expect_at(384, 1, K_MASK, 0, 0, "bnc_expired_4th");
    expect_at(390, 1, K_X, 0, 5, "bnc_hold_x_inactive");
    expect_at(390, 1, K_Y, 0, 250, "bnc_hold_y_inactive");
    for (int f = 1; f <= 390; f++) begin
      keycode = (f == 1) ? {8'h00, FIRE, 16'h0000} : 32'd0;
      tick();
      while (sb.size() > 0 && sb[0].frame == frame) begin
        e = sb.pop_front(); got = observe(e.inst, e.kind, e.slot); checks++;
        if (got !== e.val) begin errors++; $display("FAIL %s frame %0d: got %0d, expected %0d", e.name, frame, got, e.val); end
      end
    end
  endtask

  task automatic test_lifetime();
    exp_t e; logic [31:0] got;
    do_reset();
    expect_at(1, 2, K_MASK, 0, 1, "life_frame1");
    expect_at(1, 2, K_X, 0, 300, "life_x1");
    expect_at(2, 2, K_MASK, 0, 1, "life_frame2");
    expect_at(2, 2, K_X, 0, 305, "life_x2");
    expect_at(3, 2, K_MASK, 0, 1, "life_frame3");
    expect_at(3, 2, K_X, 0, 310, "life_x3");
    expect_at(4, 2, K_MASK, 0, 0, "life_expired");
    expect_at(6, 2, K_MASK, 0, 0, "life_stays_idle");
    for (int f = 1; f <= 6; f++) begin
      keycode = (f == 1) ? {24'd0, FIRE} : 32'd0;
      tick();
      while (sb.size() > 0 && sb[0].frame == frame) begin
        e = sb.pop_front(); got = observe(e.inst, e.kind, e.slot); checks++;
        if (got !== e.val) begin errors++; $display("FAIL %s frame %0d: got %0d, expected %0d", e.name, frame, got, e.val); end
      end
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    keycode = {24'd0, FIRE};
    tick();
    keycode = 32'd0;
    tick(); tick();
    checks++; if (d_act !== 4'b0001) begin errors++; $display("FAIL async_pre_active: got %b, expected 0001", d_act); end
    #2 Reset = 1'b0;
    #1;
    checks++; if (d_act !== 4'b0000) begin errors++; $display("FAIL async_active_clear: got %b, expected 0000", d_act); end
    checks++; if (d_x !== '0) begin errors++; $display("FAIL async_x_clear: got %h, expected 0", d_x); end
  endtask

`ifdef SHELL_KILL_EN
  task automatic test_kill();
    exp_t e; logic [31:0] got;
    do_reset();
    expect_at(33, 0, K_MASK, 0, 4'b0111, "kill_three_live");
    expect_at(40, 0, K_MASK, 0, 4'b0101, "kill_slot1_cleared");
    expect_at(40, 0, K_X, 0, 495, "kill_slot0_unaffected");
    expect_at(41, 0, K_MASK, 0, 4'b0101, "kill_stays_cleared");
    expect_at(49, 0, K_MASK, 0, 4'b0111, "kill_ignored_on_alloc");
    expect_at(50, 0, K_MASK, 0, 4'b0111, "kill_alloc_survives");
    for (int f = 1; f <= 50; f++) begin
      keycode = (f == 1 || f == 17 || f == 33 || f == 49) ? {24'd0, FIRE} : 32'd0;
      kill_v  = (f == 40 || f == 49) ? 4'b0010 : 4'b0000;
      tick();
      while (sb.size() > 0 && sb[0].frame == frame) begin
        e = sb.pop_front(); got = observe(e.inst, e.kind, e.slot); checks++;
        if (got !== e.val) begin errors++; $display("FAIL %s frame %0d: got %0d, expected %0d", e.name, frame, got, e.val); end
      end
    end
    kill_v = '0;
  endtask
`endif

  initial begin
    test_reset();
    test_fire_held();
    test_heading();
    test_alloc_full();
    test_cooldown();
    test_bounce();
    test_lifetime();
    test_async_reset();
`ifdef SHELL_KILL_EN
    test_kill();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
